chacha_bus_master: RTL and testbench

// - Bus master (initiator) for the chacha register slave. Drives its read/write/addr/write_data port; consumes read_data.
// - Takes a job over a valid/ready handshake: key, iv, rounds, 512-bit data block and an init/next selector.
// - Programs the slave, starts the core, polls status, then reads the 16 result words back.
// - Returns the result block over a second valid/ready handshake. Sits between a DMA/CPU front end and the chacha slave.
//

---
 rtl/chacha_bus_pkg.sv | 40 ++++
 rtl/chacha_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_chacha_bus_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_bus_pkg.sv
// chacha bus master shared definitions.
// Slave register map, control/status bits and FSM encoding.
package chacha_bus_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_ROUNDS    = 8'h0b;
  localparam logic [7:0] ADDR_KEY0      = 8'h10;
  localparam logic [7:0] ADDR_IV0       = 8'h20;
  localparam logic [7:0] ADDR_DATA_IN0  = 8'h40;
  localparam logic [7:0] ADDR_DATA_OUT0 = 8'h80;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_IV,
    ST_WR_ROUNDS,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_WR_CLR,
    ST_WAIT,
    ST_POLL,
    ST_RD_OUT,
    ST_RESULT
  } state_t;

  // Word i of a big-endian packed block, word0 in the top bits.
  function automatic logic [31:0] word_of(
    input logic [511:0] v,
    input logic [3:0]   i
  );
    return v[32*(15-int'(i)) +: 32];
  endfunction

endpackage

// File: rtl/chacha_bus_master.sv
// chacha bus master: programs the slave, polls status,
// reads the result block back and returns it to the requester.
module chacha_bus_master
  import chacha_bus_pkg::*;
#(
  parameter int POLL_DELAY   = 2,
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic         job_init,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_iv,
  input  logic [4:0]   job_rounds,
  input  logic [511:0] job_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [511:0] res_data,
  output logic         res_timeout,
  output logic         read,
  output logic         write,
  output logic [7:0]   addr,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int WAIT_LAST =
    (POLL_DELAY > 0) ? POLL_DELAY - 1 : 0;
  localparam logic [PW-1:0] P_LAST = PW'(POLL_TIMEOUT - 1);
  localparam logic [PW-1:0] W_LAST = PW'(WAIT_LAST);

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [PW-1:0] pcnt;
  logic          init_r;
  logic [255:0]  key_r;
  logic [95:0]   iv_r;
  logic [4:0]    rounds_r;
  logic [511:0]  data_r;
  logic          st_done;

  assign cnt_nxt   = cnt + 4'd1;
  assign job_ready = (state == ST_IDLE);
  assign st_done   = read_data[STATUS_VALID_BIT] &
                     read_data[STATUS_READY_BIT];

  // Job sequencer: each state holds the access now on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      write_data  <= '0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
      res_data    <= '0;
      init_r      <= 1'b0;
      key_r       <= '0;
      iv_r        <= '0;
      rounds_r    <= '0;
      data_r      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (job_valid) begin
            init_r   <= job_init;
            key_r    <= job_key;
            iv_r     <= job_iv;
            rounds_r <= job_rounds;
            data_r   <= job_data;
            res_data <= '0;
            cnt      <= '0;
            write    <= 1'b1;
            if (job_init) begin
              state      <= ST_WR_KEY;
              addr       <= ADDR_KEY0;
              write_data <= job_key[255:224];
            end else begin
              state      <= ST_WR_DATA;
              addr       <= ADDR_DATA_IN0;
              write_data <= job_data[511:480];
            end
          end
        end
        ST_WR_KEY: begin
          if (cnt == 4'd7) begin
            state      <= ST_WR_IV;
            cnt        <= '0;
            addr       <= ADDR_IV0;
            write_data <= iv_r[95:64];
          end else begin
            cnt        <= cnt_nxt;
            addr       <= ADDR_KEY0 + {4'h0, cnt_nxt};
            write_data <= word_of({key_r, 256'h0}, cnt_nxt);
          end
        end
        ST_WR_IV: begin
          if (cnt == 4'd2) begin
            state      <= ST_WR_ROUNDS;
            cnt        <= '0;
            addr       <= ADDR_ROUNDS;
            write_data <= {27'h0, rounds_r};
          end else begin
            cnt        <= cnt_nxt;
            addr       <= ADDR_IV0 + {4'h0, cnt_nxt};
            write_data <= word_of({iv_r, 416'h0}, cnt_nxt);
          end
        end
        ST_WR_ROUNDS: begin
          state      <= ST_WR_DATA;
          cnt        <= '0;
          addr       <= ADDR_DATA_IN0;
          write_data <= data_r[511:480];
        end
        ST_WR_DATA: begin
          if (cnt == 4'd15) begin
            state      <= ST_WR_CTRL;
            cnt        <= '0;
            addr       <= ADDR_CTRL;
            write_data <= 32'(1) << (init_r ? CTRL_INIT_BIT
                                            : CTRL_NEXT_BIT);
          end else begin
            cnt        <= cnt_nxt;
            addr       <= ADDR_DATA_IN0 + {4'h0, cnt_nxt};
            write_data <= word_of(data_r, cnt_nxt);
          end
        end
        ST_WR_CTRL: begin
          state      <= ST_WR_CLR;
          cnt        <= '0;
          write_data <= '0;
        end
        ST_WR_CLR: begin
          write <= 1'b0;
          cnt   <= '0;
          pcnt  <= '0;
          if (POLL_DELAY == 0) begin
            state <= ST_POLL;
            read  <= 1'b1;
            addr  <= ADDR_STATUS;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pcnt == W_LAST) begin
            state <= ST_POLL;
            pcnt  <= '0;
            read  <= 1'b1;
            addr  <= ADDR_STATUS;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_POLL: begin
          if (st_done) begin
            state <= ST_RD_OUT;
            cnt   <= '0;
            pcnt  <= '0;
            addr  <= ADDR_DATA_OUT0;
          end else if (pcnt == P_LAST) begin
            state       <= ST_RESULT;
            pcnt        <= '0;
            read        <= 1'b0;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
            res_data    <= '0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_RD_OUT: begin
          res_data[32*(15-int'(cnt)) +: 32] <= read_data;
          if (cnt == 4'd15) begin
            state     <= ST_RESULT;
            cnt       <= '0;
            read      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            cnt  <= cnt_nxt;
            addr <= ADDR_DATA_OUT0 + {4'h0, cnt_nxt};
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            state       <= ST_IDLE;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_bus_master.sv
// Bench for chacha_bus_master: slave model, bus monitor
// and a transaction-level model of the expected traffic.
module tb_chacha_bus_master;

  localparam int PD = 2;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic         job_init = 1'b0;
  logic [255:0] job_key = '0;
  logic [95:0]  job_iv = '0;
  logic [4:0]   job_rounds = '0;
  logic [511:0] job_data = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [511:0] res_data;
  logic         res_timeout;
  logic         read;
  logic         write;
  logic [7:0]   addr;
  logic [31:0]  write_data;
  logic [31:0]  read_data;

  always #5 clk = ~clk;

  chacha_bus_master #(
    .POLL_DELAY(PD),
    .POLL_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_init(job_init),
    .job_key(job_key),
    .job_iv(job_iv),
    .job_rounds(job_rounds),
    .job_data(job_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_timeout(res_timeout),
    .read(read),
    .write(write),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data)
  );

  // slave model
  int          status_reads = 0;
  int          stat_base = 0;
  int          busy_n = 0;
  logic [31:0] out_w [16];

  always @(posedge clk)
    if (reset_n && read && addr == 8'h09)
      status_reads <= status_reads + 1;

  always_comb begin
    read_data = 32'h0;
    if (read) begin
      if (addr == 8'h09)
        read_data = (status_reads - stat_base >= busy_n)
                    ? 32'h3 : 32'h1;
      else if (addr[7:4] == 4'h8)
        read_data = out_w[addr[3:0]];
      else
        read_data = {24'hDEAD00, addr};
    end
  end

  typedef struct {
    bit          rd;
    logic [7:0]  a;
    logic [31:0] d;
    int          gap;
  } bus_t;

  typedef struct {
    logic [511:0] d;
    bit           to;
  } res_t;

  bus_t exp_q[$];
  res_t res_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int n_wr = 0;
  int n_stat = 0;
  int n_out = 0;
  bit acc_now, hs_now, rv_now, hold_prev;
  logic [511:0] prev_d;
  logic         prev_t;
  logic [7:0]   seen_wr_addr;
  bit           seen_wr;

  function automatic void chk(bit ok, string nm,
                              logic [63:0] act,
                              logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // compare process body, run once per cycle at negedge
  function automatic void mon();
    bus_t e;
    res_t r;
    cyc++;
    acc_now = 0;
    hs_now  = 0;
    rv_now  = 0;
    seen_wr = 0;
    if (!reset_n) begin
      hold_prev = 0;
      return;
    end
    chk(!(read && write), "excl", {read, write}, 2'b00);
    if (read || write) begin
      if (exp_q.size() == 0) begin
        chk(0, "stray", {read, write, addr}, 0);
      end else begin
        e = exp_q.pop_front();
        chk(read == e.rd && addr == e.a &&
            (e.rd || write_data == e.d) &&
            cyc - last_cyc == e.gap, "bus",
            {read, addr, write_data, 8'(cyc - last_cyc)},
            {e.rd, e.a, e.d, 8'(e.gap)});
      end
      if (write) begin
        n_wr++;
        seen_wr = 1;
        seen_wr_addr = addr;
      end
      if (read && addr == 8'h09) n_stat++;
      if (read && addr[7:4] == 4'h8) n_out++;
      last_cyc = cyc;
    end
    if (res_valid) begin
      rv_now = 1;
      if (hold_prev)
        chk(res_data == prev_d && res_timeout == prev_t,
            "res_stable", res_data[63:0], prev_d[63:0]);
    end
    hold_prev = res_valid && !res_ready;
    prev_d = res_data;
    prev_t = res_timeout;
    if (res_valid && res_ready) begin
      hs_now = 1;
      hs_cyc = cyc;
      if (res_q.size() == 0) begin
        chk(0, "res_unexp", 1, 0);
      end else begin
        r = res_q.pop_front();
        chk(res_timeout == r.to, "res_to", res_timeout, r.to);
        for (int i = 0; i < 16; i++)
          chk(res_data[32*(15-i) +: 32] == r.d[32*(15-i) +: 32],
              $sformatf("res_w%0d", i),
              res_data[32*(15-i) +: 32], r.d[32*(15-i) +: 32]);
      end
    end
    if (job_valid && job_ready) begin
      acc_now = 1;
      acc_cyc = cyc;
      last_cyc = cyc;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_w(logic [7:0] a, logic [31:0] d,
                                 int gap);
    bus_t e;
    e.rd = 0; e.a = a; e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  function automatic void push_r(logic [7:0] a, int gap);
    bus_t e;
    e.rd = 1; e.a = a; e.d = 0; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  // expected traffic and result derived from the register map
  function automatic void model(bit init, logic [255:0] k,
                                logic [95:0] v, logic [4:0] rn,
                                logic [511:0] d, int busy);
    res_t r;
    int   np;
    if (init) begin
      for (int i = 0; i < 8; i++)
        push_w(8'h10 + 8'(i), k[255-32*i -: 32], 1);
      for (int i = 0; i < 3; i++)
        push_w(8'h20 + 8'(i), v[95-32*i -: 32], 1);
      push_w(8'h0b, {27'h0, rn}, 1);
    end
    for (int i = 0; i < 16; i++)
      push_w(8'h40 + 8'(i), d[511-32*i -: 32], 1);
    push_w(8'h08, init ? 32'h1 : 32'h2, 1);
    push_w(8'h08, 32'h0, 1);
    np = (busy + 1 <= TO) ? busy + 1 : TO;
    for (int i = 0; i < np; i++)
      push_r(8'h09, (i == 0) ? PD + 1 : 1);
    r.d = '0;
    r.to = (busy >= TO);
    if (!r.to) begin
      for (int i = 0; i < 16; i++) begin
        push_r(8'h80 + 8'(i), 1);
        r.d[32*(15-i) +: 32] = out_w[i];
      end
    end
    res_q.push_back(r);
  endfunction

  int b_wr, b_stat, b_out;

  task automatic offer(bit init, logic [255:0] k, logic [95:0] v,
                       logic [4:0] rn, logic [511:0] d, int busy);
    busy_n = busy;
    stat_base = status_reads;
    b_wr = n_wr; b_stat = n_stat; b_out = n_out;
    job_init = init; job_key = k; job_iv = v;
    job_rounds = rn; job_data = d;
    model(init, k, v, rn, d, busy);
    job_valid = 1'b1;
  endtask

  task automatic wait_acc();
    int n = 0;
    do begin
      step();
      n++;
    end while (!acc_now && n < 200);
    chk(acc_now, "accept_timeout", n, 0);
    job_valid = 1'b0;
    job_key = {8{$urandom}};
    job_data = {16{$urandom}};
    job_iv = {3{$urandom}};
    job_init = $urandom;
  endtask

  task automatic start(bit init, logic [255:0] k, logic [95:0] v,
                       logic [4:0] rn, logic [511:0] d, int busy);
    offer(init, k, v, rn, d, busy);
    wait_acc();
  endtask

  task automatic wait_res();
    int n = 0;
    do begin
      step();
      n++;
    end while (!rv_now && n < 400);
    chk(rv_now, "res_wait_timeout", n, 0);
  endtask

  task automatic take(int hold);
    repeat (hold) step();
    res_ready = 1'b1;
    step();
    chk(hs_now, "handshake", hs_now, 1);
    res_ready = 1'b0;
  endtask

  task automatic rand_out();
    for (int i = 0; i < 16; i++) out_w[i] = $urandom;
  endtask

  logic [255:0] k0;
  logic [511:0] d0;
  int           n;

  initial begin
    for (int i = 0; i < 16; i++) out_w[i] = 32'hA000_0000 + i;
    k0 = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    for (int i = 0; i < 16; i++)
      d0[32*(15-i) +: 32] = 32'h1111_0000 * (i + 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk({read, write, addr, write_data} == '0, "rst_bus",
        {read, write, addr, write_data}, 0);
    chk({res_valid, res_timeout} == 2'b00, "rst_res",
        {res_valid, res_timeout}, 0);
    chk(res_data == '0, "rst_data", res_data[63:0], 0);
    chk(job_ready == 1'b1, "rst_ready", job_ready, 1);
    reset_n = 1'b1;
    step();

    // init job: 30 writes, one poll, 16 reads
    start(1, k0, {32'd1, 32'd2, 32'd3}, 5'd20, d0, 0);
    wait_res();
    chk(n_wr - b_wr == 30, "t1_writes", n_wr - b_wr, 30);
    chk(n_stat - b_stat == 1, "t1_polls", n_stat - b_stat, 1);
    take(0);

    // next-block job: 18 writes
    start(0, {8{$urandom}}, {3{$urandom}}, 5'd8, d0, 0);
    wait_res();
    chk(n_wr - b_wr == 18, "t2_writes", n_wr - b_wr, 18);
    take(1);

    // five busy polls then done
    start(0, '0, '0, 5'd0, {16{$urandom}}, 5);
    wait_res();
    chk(n_stat - b_stat == 6, "t3_polls", n_stat - b_stat, 6);
    chk(n_out - b_out == 16, "t3_reads", n_out - b_out, 16);
    chk(res_data[511:480] == 32'hA000_0000, "t3_w0",
        res_data[511:480], 32'hA000_0000);
    chk(res_data[31:0] == 32'hA000_000F, "t3_w15",
        res_data[31:0], 32'hA000_000F);
    take(2);

    // status stuck busy: timeout after TO polls
    start(1, {8{$urandom}}, {3{$urandom}}, 5'd12, d0, 1000);
    wait_res();
    chk(n_stat - b_stat == 8, "t4_polls", n_stat - b_stat, 8);
    chk(n_out - b_out == 0, "t4_reads", n_out - b_out, 0);
    chk(res_timeout == 1'b1, "t4_to", res_timeout, 1);
    chk(res_data == '0, "t4_zero", res_data[63:0], 0);
    take(0);

    // backpressure with a pending job behind it
    rand_out();
    start(1, {8{$urandom}}, {3{$urandom}}, 5'd20, {16{$urandom}}, 1);
    wait_res();
    rand_out();
    offer(0, '0, '0, 5'd0, {16{$urandom}}, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk(!job_ready, "t5_ready", job_ready, 0);
    end
    take(0);
    wait_acc();
    chk(acc_cyc == hs_cyc + 1, "t5_acc", acc_cyc, hs_cyc + 1);
    wait_res();
    take(0);

    // reset in the middle of the data block
    start(1, {8{$urandom}}, {3{$urandom}}, 5'd20, {16{$urandom}}, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!(seen_wr && seen_wr_addr == 8'h45) && n < 100);
    chk(n < 100, "t6_reach", n, 0);
    reset_n = 1'b0;
    #1;
    chk({read, write, res_valid} == 3'b000, "t6_async",
        {read, write, res_valid}, 0);
    exp_q.delete();
    res_q.delete();
    repeat (3) step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(job_ready, "t6_ready", job_ready, 1);
    end

    // random jobs
    for (int j = 0; j < 8; j++) begin
      rand_out();
      start($urandom_range(0, 1), {8{$urandom}}, {3{$urandom}},
            5'($urandom), {16{$urandom}}, $urandom_range(0, 9));
      wait_res();
      take($urandom_range(0, 3));
    end

    repeat (5) step();
    chk(exp_q.size() == 0, "exp_left", exp_q.size(), 0);
    chk(res_q.size() == 0, "res_left", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
